sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param_if.sv | 33 +++
 rtl/sync_fifo_param.sv | 91 +++++++++
 tb/tb_sync_fifo_param.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - write/read/status bundle for sync_fifo_param
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clr;
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output clr, wr_en, din, rd_en,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, din, rd_en,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with registered read data and sticky error flags
module sync_fifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_TH  = DEPTH - 2,
  parameter int AE_TH  = 2
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_param_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C   = (ADDR_W+1)'(AF_TH);
  localparam logic [ADDR_W:0] AE_C   = (ADDR_W+1)'(AE_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              overflow;
  logic              underflow;
  logic              full;
  logic              empty;
  logic              wr_acc;
  logic              rd_acc;

  // Flags come from the count register only, so they never depend on this cycle's requests.
  assign full   = (count == FULL_C);
  assign empty  = (count == '0);
  assign wr_acc = bus.wr_en && !full  && !bus.clr;
  assign rd_acc = bus.rd_en && !empty && !bus.clr;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr] <= bus.din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (bus.clr) begin
      // Flush leaves dout and memory untouched.
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_acc) begin
        rptr <= rptr + 1'b1;
        dout <= mem[rptr];
      end
      dout_valid <= rd_acc;
      if (wr_acc && !rd_acc) begin
        count <= count + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count <= count - 1'b1;
      end
      if (bus.wr_en && full) begin
        overflow <= 1'b1;
      end
      if (bus.rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  assign bus.dout         = dout;
  assign bus.dout_valid   = dout_valid;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= AF_C);
  assign bus.almost_empty = (count <= AE_C);
  assign bus.count        = count;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param
module tb_sync_fifo_param;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) bus ();

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_TH(14), .AE_TH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge with the given requests; returns 1 ns after the edge with requests idle.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    bus.wr_en = w;
    bus.din   = d;
    bus.rd_en = r;
    bus.clr   = c;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.clr   = 1'b0;
  endtask

  task automatic check_thresholds(input string tag, input int cnt);
    check({tag, "_count"}, 32'(bus.count), 32'(cnt));
    check({tag, "_ae"}, 32'(bus.almost_empty), 32'(cnt <= 2));
    check({tag, "_af"}, 32'(bus.almost_full), 32'(cnt >= 14));
    check({tag, "_full"}, 32'(bus.full), 32'(cnt == 16));
    check({tag, "_empty"}, 32'(bus.empty), 32'(cnt == 0));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    bus.clr = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din = 8'h00;
    #12;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_ae", 32'(bus.almost_empty), 32'd1);
    check("rst_af", 32'(bus.almost_full), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_dvalid", 32'(bus.dout_valid), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_udf", 32'(bus.underflow), 32'd0);
    rst = 1'b1;

    // Fill 0x00..0x0F with a threshold sweep on the way up.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      check_thresholds("fill", i + 1);
    end
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf_set", 32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd16);

    // Drain: order preserved, 0xAA never appears, sweep on the way down.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_dout", 32'(bus.dout), 32'(i));
      check("drain_dvalid", 32'(bus.dout_valid), 32'd1);
      check_thresholds("drain", 15 - i);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("idle_dvalid", 32'(bus.dout_valid), 32'd0);
    check("idle_dout_hold", 32'(bus.dout), 32'h0F);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);
    check("udf_clear", 32'(bus.underflow), 32'd0);

    // Read while empty.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("udf_set", 32'(bus.underflow), 32'd1);
    check("udf_dvalid", 32'(bus.dout_valid), 32'd0);
    check("udf_dout", 32'(bus.dout), 32'h0F);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("empty_rw_count", 32'(bus.count), 32'd1);
    check("empty_rw_dvalid", 32'(bus.dout_valid), 32'd0);

    // Synchronous flush with one entry stored and both sticky flags set.
    step(1'b1, 8'h66, 1'b1, 1'b1);
    check("clr_count", 32'(bus.count), 32'd0);
    check("clr_empty", 32'(bus.empty), 32'd1);
    check("clr_ovf", 32'(bus.overflow), 32'd0);
    check("clr_udf", 32'(bus.underflow), 32'd0);
    check("clr_dout_hold", 32'(bus.dout), 32'h0F);
    check("clr_dvalid", 32'(bus.dout_valid), 32'd0);

    // Count 8, then 20 simultaneous read+write cycles across the pointer wrap.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    check("rw_pre_count", 32'(bus.count), 32'd8);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(8'h18 + i), 1'b1, 1'b0);
      check("rw_dout", 32'(bus.dout), 32'(8'h10 + i));
      check("rw_count", 32'(bus.count), 32'd8);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("rw_tail", 32'(bus.dout), 32'(8'h24 + i));
    end
    check("rw_empty", 32'(bus.empty), 32'd1);

    // Full with both requests: read wins, write rejected.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    check("full_rw_dout", 32'(bus.dout), 32'h30);
    check("full_rw_count", 32'(bus.count), 32'd15);
    check("full_rw_ovf", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_rst_dout", 32'(bus.dout), 32'h3A);
    check("pre_rst_count", 32'(bus.count), 32'd5);

    // Asynchronous reset pulsed between edges.
    #2;
    rst = 1'b0;
    #1;
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_empty", 32'(bus.empty), 32'd1);
    check("arst_ovf", 32'(bus.overflow), 32'd0);
    check("arst_dout", 32'(bus.dout), 32'd0);
    rst = 1'b1;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    check("post_rst_count", 32'(bus.count), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_dout", 32'(bus.dout), 32'h77);
    check("post_rst_empty", 32'(bus.empty), 32'd1);

    // Count 5 with overflow, then a clr edge.
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_clr_count", 32'(bus.count), 32'd5);
    check("pre_clr_ovf", 32'(bus.overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr2_count", 32'(bus.count), 32'd0);
    check("clr2_empty", 32'(bus.empty), 32'd1);
    check("clr2_ovf", 32'(bus.overflow), 32'd0);
    check("clr2_ae", 32'(bus.almost_empty), 32'd1);
    check("clr2_dout_hold", 32'(bus.dout), 32'h4A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
